// File: rtl/dm9x9_pkg.sv
// ----------------------------------------------------------------------------
// dm9x9_pkg
// Shared types and constants for the 9x9 window sequencer.
//   state_e : sequencer FSM states
//   KSIZE   : window edge length in pixels
//   KHALF   : half window (pixels from the centre to an edge)
// ----------------------------------------------------------------------------
package dm9x9_pkg;

  localparam int KSIZE = 9;
  localparam int KHALF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bottom-right pixel coordinate from which a full KSIZE x KSIZE window
  // exists above and to the left of it (equals KSIZE-1).
  function automatic int win_edge();
    return 2 * KHALF;
  endfunction

endpackage

// File: rtl/dm9x9_pos_counter.sv
// ----------------------------------------------------------------------------
// dm9x9_pos_counter
// Raster-order row/column counter for the next expected pixel.
//   clk, rst    : clock, synchronous active-high reset
//   clr_i       : force row/col to 0 (frame start / restart)
//   adv_i       : one pixel accepted, advance position
//   row_o/col_o : position of the next expected pixel
//   last_o      : current position is the final pixel of the frame
//   win_pos_o   : current position completes a full 9x9 window
// ----------------------------------------------------------------------------
module dm9x9_pos_counter
  import dm9x9_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o,
  output logic          win_pos_o
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
  localparam logic [CW-1:0] WIN_MIN = CW'(win_edge());

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == COL_MAX);
  assign row_end = (row_q == ROW_MAX);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (col_end) begin
        col_d = '0;
        // Final pixel of the frame wraps the row back to 0 as well.
        row_d = row_end ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign last_o    = row_end && col_end;
  assign win_pos_o = (row_q >= WIN_MIN) && (col_q >= WIN_MIN);

endmodule

// File: rtl/dm9x9_window_sequencer.sv
// ----------------------------------------------------------------------------
// dm9x9_window_sequencer
// Frame sequencer for a 9x9 sliding-window engine. Accepts a raster frame,
// drives the line-buffer shift enable, flags cycles where the window holds a
// complete in-frame neighbourhood, flushes the pipeline after the last pixel
// and pulses done_o.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start_i      : one-cycle frame start pulse
//   valid_i      : upstream pixel valid
//   ready_o      : pixel accepted on valid_i & ready_o (FILL/RUN only)
//   shift_en_o   : shift enable for line buffers / window registers
//   win_valid_o  : registered, high the cycle after a window-completing pixel
//   row_o, col_o : position of the next expected pixel
//   busy_o       : high whenever not IDLE
//   done_o       : one-cycle frame complete pulse
//
// Configuration macro: DM9_RESTART_EN
//   defined   : start_i in any busy state aborts the frame and restarts in FILL
//   undefined : start_i outside IDLE is ignored
// ----------------------------------------------------------------------------
module dm9x9_window_sequencer
  import dm9x9_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int CW        = 10,
  parameter int DRAIN_CYC = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          shift_en_o,
  output logic          win_valid_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int            DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          win_valid_q, win_valid_d;

  logic          accept;
  logic          start_hit;
  logic          last_pos;
  logic          win_pos;

  // A start that actually takes effect this cycle.
`ifdef DM9_RESTART_EN
  assign start_hit = start_i;
`else
  assign start_hit = start_i && (state_q == ST_IDLE);
`endif

  assign ready_o = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign accept  = valid_i && ready_o;

  // A restart on the same cycle as a pixel clears the counters; the pixel
  // belongs to the aborted frame and is not counted.
  dm9x9_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (start_hit),
    .adv_i     (accept),
    .row_o     (row_o),
    .col_o     (col_o),
    .last_o    (last_pos),
    .win_pos_o (win_pos)
  );

  always_comb begin
    state_d     = state_q;
    drain_d     = '0;
    win_valid_d = accept && win_pos && !start_hit;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_FILL: begin
        // The final pixel always completes a window, so check it first to
        // cover the minimum 9x9 frame where both happen on one pixel.
        if (accept && last_pos) begin
          state_d = ST_DRAIN;
        end else if (accept && win_pos) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && last_pos) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_hit) begin
      state_d = ST_FILL;
      drain_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_comb begin
    shift_en_o = 1'b0;
    case (state_q)
      ST_FILL, ST_RUN: shift_en_o = valid_i;
      ST_DRAIN:        shift_en_o = 1'b1;
      default:         shift_en_o = 1'b0;
    endcase
  end

  assign win_valid_o = win_valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  // A restart landing on the DONE cycle aborts that frame's completion.
  assign done_o      = (state_q == ST_DONE) && !start_hit;

endmodule

// File: tb/tb_dm9x9_window_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dm9x9_window_sequencer
// Directed bench for dm9x9_window_sequencer with a 16x12 frame, 5 drain cycles.
// ----------------------------------------------------------------------------
module tb_dm9x9_window_sequencer;

  localparam int IMG_W     = 16;
  localparam int IMG_H     = 12;
  localparam int CW        = 10;
  localparam int DRAIN_CYC = 5;
  localparam int NPIX      = IMG_W * IMG_H;   // 192

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          valid_i;
  logic          ready_o;
  logic          shift_en_o;
  logic          win_valid_o;
  logic [CW-1:0] row_o;
  logic [CW-1:0] col_o;
  logic          busy_o;
  logic          done_o;

  dm9x9_window_sequencer #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .CW        (CW),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .shift_en_o  (shift_en_o),
    .win_valid_o (win_valid_o),
    .row_o       (row_o),
    .col_o       (col_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-frame observations
  int cyc = 0;
  int n_acc, n_win, n_done, first_win_acc, last_acc_cyc, done_cyc, drain_shift;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_acc         = 0;
    n_win         = 0;
    n_done        = 0;
    first_win_acc = -1;
    last_acc_cyc  = -1;
    done_cyc      = -1;
    drain_shift   = 0;
  endtask

  // One clock: drive inputs after the falling edge, sample 1 ns later.
  task automatic tick(input logic s, input logic v, input logic r);
    @(negedge clk);
    start_i = s;
    valid_i = v;
    rst     = r;
    #1;
    if (win_valid_o === 1'b1) begin
      n_win++;
      if (first_win_acc < 0) first_win_acc = n_acc;
    end
    if (done_o === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy_o === 1'b1 && ready_o === 1'b0 && shift_en_o === 1'b1) drain_shift++;
    if (ready_o === 1'b1) begin
      // Position must track the number of pixels accepted so far.
      check("row_track", int'(row_o), (n_acc % NPIX) / IMG_W);
      check("col_track", int'(col_o), (n_acc % NPIX) % IMG_W);
      check("shift_eq_valid", int'(shift_en_o), int'(v));
    end else if (busy_o === 1'b1) begin
      // DRAIN/DONE: counters already wrapped, pixels ignored.
      check("drain_row", int'(row_o), 0);
      check("drain_col", int'(col_o), 0);
    end
    if (v && ready_o === 1'b1 && !r) begin
      n_acc++;
      last_acc_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic feed(input int target, input bit toggle);
    int  guard = 0;
    bit  ph    = 1'b1;
    while (n_acc < target && guard < 1000) begin
      tick(1'b0, toggle ? ph : 1'b1, 1'b0);
      ph = !ph;
      guard++;
    end
    check("feed_count", n_acc, target);
  endtask

  // Run out the drain with valid_i held at v, then verify frame statistics.
  task automatic finish_frame(input logic v);
    int guard = 0;
    while (n_done == 0 && guard < 30) begin
      tick(1'b0, v, 1'b0);
      guard++;
    end
    repeat (3) tick(1'b0, v, 1'b0);
    check("windows", n_win, 32);
    check("first_win_after_acc", first_win_acc, 137);
    check("drain_shift_cycles", drain_shift, DRAIN_CYC);
    check("done_pulses", n_done, 1);
    check("done_latency", done_cyc - last_acc_cyc, 6);
    check("idle_busy", int'(busy_o), 0);
    check("idle_ready", int'(ready_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    valid_i = 1'b0;
    clear_stats();

    // Reset held two cycles, with start/valid asserted to test priority.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_ready", int'(ready_o), 0);
    check("rst_shift", int'(shift_en_o), 0);
    check("rst_win", int'(win_valid_o), 0);
    check("rst_row", int'(row_o), 0);
    check("rst_col", int'(col_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    tick(1'b0, 1'b0, 1'b0);
    check("rst_over_start_busy", int'(busy_o), 0);

    // Frame 1: back-to-back pixels, valid held high through drain.
    clear_stats();
    tick(1'b1, 1'b0, 1'b0);
    feed(NPIX, 1'b0);
    finish_frame(1'b1);

    // Valid in IDLE is ignored.
    tick(1'b0, 1'b1, 1'b0);
    check("idle_shift", int'(shift_en_o), 0);
    tick(1'b0, 1'b1, 1'b0);
    check("idle_row", int'(row_o), 0);
    check("idle_col", int'(col_o), 0);
    check("idle_no_accept", n_acc, NPIX);

    // Frame 2: valid toggled every cycle.
    clear_stats();
    tick(1'b1, 1'b0, 1'b0);
    feed(NPIX, 1'b1);
    finish_frame(1'b0);

    // Frame 3: start_i asserted while accepting pixel 150 in RUN.
    clear_stats();
    tick(1'b1, 1'b0, 1'b0);
    feed(150, 1'b0);
    check("pre_restart_windows", n_win, 8);
    tick(1'b1, 1'b1, 1'b0);
`ifdef DM9_RESTART_EN
    clear_stats();
    tick(1'b0, 1'b0, 1'b0);
    check("restart_row", int'(row_o), 0);
    check("restart_col", int'(col_o), 0);
    check("restart_fill", int'(ready_o), 1);
    check("restart_no_win", int'(win_valid_o), 0);
    feed(NPIX, 1'b0);
    finish_frame(1'b0);
`else
    feed(NPIX, 1'b0);
    finish_frame(1'b0);
`endif

    // Frame 4: reset while accepting pixel 100, then a clean frame.
    clear_stats();
    tick(1'b1, 1'b0, 1'b0);
    feed(100, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_row", int'(row_o), 0);
    check("abort_col", int'(col_o), 0);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    check("abort_no_done", n_done, 0);
    clear_stats();
    tick(1'b1, 1'b0, 1'b0);
    feed(NPIX, 1'b0);
    finish_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
